// File: rtl/id_stage_pipe.sv
// RV32 instruction-decode stage: field/immediate decode, register operand
// select with write-back bypass, load-use bubble insertion and a registered
// ID/EX slot under a valid/ready handshake with flush.
module id_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter bit          HAS_M  = 1'b1,
  parameter bit          HAS_A  = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [31:0]       if_instr_i,
  input  logic [DATA_W-1:0] if_pc_i,
  output logic [4:0]        rf_rs1_addr_o,
  output logic [4:0]        rf_rs2_addr_o,
  input  logic [DATA_W-1:0] rf_a_i,
  input  logic [DATA_W-1:0] rf_b_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [DATA_W-1:0] ex_rs1_val_o,
  output logic [DATA_W-1:0] ex_rs2_val_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rd_o,
  output logic              ex_rd_we_o,
  output logic              ex_is_load_o,
  output logic [2:0]        ex_fu_sel_o,
  output logic              ex_illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_AMO    = 7'b0101111;

  typedef enum logic [2:0] {
    FU_ALU     = 3'd0,
    FU_MULDIV  = 3'd1,
    FU_LSU     = 3'd2,
    FU_BRANCH  = 3'd3,
    FU_SYSTEM  = 3'd4,
    FU_AMO     = 3'd5,
    FU_ILLEGAL = 3'd7
  } fu_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = if_instr_i[6:0];
  assign funct3 = if_instr_i[14:12];
  assign funct7 = if_instr_i[31:25];
  assign rs1    = if_instr_i[19:15];
  assign rs2    = if_instr_i[24:20];
  assign rd     = if_instr_i[11:7];

  assign rf_rs1_addr_o = rs1;
  assign rf_rs2_addr_o = rs2;

  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = DATA_W'($signed(if_instr_i[31:20]));
  assign imm_s = DATA_W'($signed({if_instr_i[31:25], if_instr_i[11:7]}));
  assign imm_b = DATA_W'($signed({if_instr_i[31], if_instr_i[7], if_instr_i[30:25],
                                  if_instr_i[11:8], 1'b0}));
  assign imm_u = DATA_W'($signed({if_instr_i[31:12], 12'b0}));
  assign imm_j = DATA_W'($signed({if_instr_i[31], if_instr_i[19:12], if_instr_i[20],
                                  if_instr_i[30:21], 1'b0}));

  fu_e               dec_fu;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal, dec_is_load, dec_writes_rd;
  logic              uses_rs1, uses_rs2;

  // Opcode decode; an illegal slot is normalised to fu=7, imm=0, no write.
  always_comb begin
    dec_fu        = FU_ILLEGAL;
    dec_imm       = '0;
    dec_illegal   = 1'b0;
    dec_is_load   = 1'b0;
    dec_writes_rd = 1'b1;
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    case (opcode)
      OPC_LOAD:   begin dec_fu = FU_LSU; dec_imm = imm_i; dec_is_load = 1'b1; end
      OPC_STORE:  begin dec_fu = FU_LSU; dec_imm = imm_s; uses_rs2 = 1'b1; dec_writes_rd = 1'b0; end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (funct7 == 7'b0000001) begin
          dec_fu      = FU_MULDIV;
          dec_illegal = !HAS_M;
        end else begin
          dec_fu = FU_ALU;
        end
      end
      OPC_OP_IMM: begin dec_fu = FU_ALU; dec_imm = imm_i; end
      OPC_LUI:    begin dec_fu = FU_ALU; dec_imm = imm_u; uses_rs1 = 1'b0; end
      OPC_AUIPC:  begin dec_fu = FU_ALU; dec_imm = imm_u; uses_rs1 = 1'b0; end
      OPC_BRANCH: begin dec_fu = FU_BRANCH; dec_imm = imm_b; uses_rs2 = 1'b1; dec_writes_rd = 1'b0; end
      OPC_JAL:    begin dec_fu = FU_BRANCH; dec_imm = imm_j; uses_rs1 = 1'b0; end
      OPC_JALR:   begin dec_fu = FU_BRANCH; dec_imm = imm_i; end
      OPC_SYSTEM: begin dec_fu = FU_SYSTEM; dec_imm = imm_i; end
      OPC_AMO: begin
        dec_fu      = FU_AMO;
        uses_rs2    = 1'b1;
        dec_illegal = !HAS_A || (funct3 != 3'b010);
      end
      default:    dec_illegal = 1'b1;
    endcase
    if (if_instr_i[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) begin
      dec_fu        = FU_ILLEGAL;
      dec_imm       = '0;
      dec_is_load   = 1'b0;
      dec_writes_rd = 1'b0;
    end
  end

  // Operand select: x0 first, then write-back bypass, then RF read data.
  logic [DATA_W-1:0] op_a, op_b;
  assign op_a = (rs1 == 5'd0) ? '0 :
                (wb_we_i && (wb_rd_i == rs1)) ? wb_data_i : rf_a_i;
  assign op_b = (rs2 == 5'd0) ? '0 :
                (wb_we_i && (wb_rd_i == rs2)) ? wb_data_i : rf_b_i;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
  logic [4:0]        ex_rd_q;
  logic              ex_rd_we_q, ex_is_load_q, ex_illegal_q;
  logic [2:0]        ex_fu_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              capture;

  logic lu, adv;
  assign lu  = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
               ((uses_rs1 && (rs1 == ex_rd_q)) || (uses_rs2 && (rs2 == ex_rd_q)));
  assign adv = !ex_valid_q || ex_ready_i;

  // Ready is forced high in reset so fetch never sees a stuck stage.
  assign if_ready_o = !rst_ni || flush_i || (adv && !lu);

  // Slot next-state: flush beats bubble beats capture beats drain.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    capture     = 1'b0;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (adv) begin
      if (lu) begin
        ex_valid_d = 1'b0;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (if_valid_i) begin
        ex_valid_d = 1'b1;
        capture    = 1'b1;
      end else begin
        ex_valid_d = 1'b0;
      end
    end
  end

  // ID/EX slot register; payload only moves on capture so bubbles keep it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_valid_q   <= 1'b0;
      stall_cnt_q  <= '0;
      ex_pc_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      ex_rd_we_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_fu_q      <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (capture) begin
        ex_pc_q      <= if_pc_i;
        ex_rs1_q     <= op_a;
        ex_rs2_q     <= op_b;
        ex_imm_q     <= dec_imm;
        ex_rd_q      <= rd;
        ex_rd_we_q   <= dec_writes_rd && (rd != 5'd0);
        ex_is_load_q <= dec_is_load;
        ex_fu_q      <= dec_fu;
        ex_illegal_q <= dec_illegal;
      end
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_pc_o      = ex_pc_q;
  assign ex_rs1_val_o = ex_rs1_q;
  assign ex_rs2_val_o = ex_rs2_q;
  assign ex_imm_o     = ex_imm_q;
  assign ex_rd_o      = ex_rd_q;
  assign ex_rd_we_o   = ex_rd_we_q;
  assign ex_is_load_o = ex_is_load_q;
  assign ex_fu_sel_o  = ex_fu_q;
  assign ex_illegal_o = ex_illegal_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
